// File: rtl/predictor_fifo_ctrl_if.sv
// predictor_fifo_ctrl_if: push, head, resolve and status signals of the branch-predictor FIFO controller.
interface predictor_fifo_ctrl_if #(parameter int PTR_W = 3);
    logic             push_valid;
    logic [24:0]      push_data;
    logic             push_ready;
    logic             head_valid;
    logic [24:0]      head_data;
    logic             resolve_valid;
    logic [10:0]      resolve_addr;
    logic             resolve_taken;
    logic [10:0]      resolve_target;
    logic             mispredict;
    logic [10:0]      redirect_addr;
    logic             flush;
    logic [PTR_W:0]   count;
    logic             underflow_err;
    logic             sync_err;
    modport master (
        output push_valid, push_data, resolve_valid, resolve_addr, resolve_taken, resolve_target,
        input  push_ready, head_valid, head_data, mispredict, redirect_addr, flush, count,
               underflow_err, sync_err
    );
    modport slave (
        input  push_valid, push_data, resolve_valid, resolve_addr, resolve_taken, resolve_target,
        output push_ready, head_valid, head_data, mispredict, redirect_addr, flush, count,
               underflow_err, sync_err
    );
endinterface

// File: rtl/predictor_fifo_ctrl.sv
// predictor_fifo_ctrl: prediction FIFO that retires entries on resolve and flushes/redirects on mispredict.
module predictor_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic clk,
    input  logic reset_n,
    predictor_fifo_ctrl_if.slave bus
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t           state;
    logic [24:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   cnt;
    logic             mis_q, flush_q, uf_q, se_q;
    logic [10:0]      redir_q;
    logic             run, do_push, do_res, addr_bad, mis;
    logic [24:0]      head;
    logic [10:0]      redir;
    assign run      = state == RUN;
    assign head     = mem[rd_ptr];
    assign do_push  = bus.push_valid && bus.push_ready;
    assign do_res   = bus.resolve_valid && run && cnt != '0;
    assign addr_bad = bus.resolve_addr != head[24:14];
    assign mis      = do_res && (addr_bad || bus.resolve_taken != head[0] ||
                      (bus.resolve_taken && head[0] && bus.resolve_target != head[13:3]));
    assign redir    = bus.resolve_taken ? bus.resolve_target : bus.resolve_addr + 11'd1;
    assign bus.push_ready    = run && cnt != (PTR_W+1)'(DEPTH);
    assign bus.head_valid    = run && cnt != '0;
    assign bus.head_data     = head;
    assign bus.count         = cnt;
    assign bus.mispredict    = mis_q;
    assign bus.flush         = flush_q;
    assign bus.redirect_addr = redir_q;
    assign bus.underflow_err = uf_q;
    assign bus.sync_err      = se_q;
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= bus.push_data;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            mis_q   <= 1'b0;
            flush_q <= 1'b0;
            redir_q <= '0;
            uf_q    <= 1'b0;
            se_q    <= 1'b0;
        end else if (state == FLUSH) begin
            // wrong-path entries, including any pushed with the mispredict, are dropped here
            state   <= RUN;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            mis_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_res) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_res);
            if (bus.resolve_valid && cnt == '0) uf_q <= 1'b1;
            if (do_res && addr_bad) se_q <= 1'b1;
            if (mis) begin
                state   <= FLUSH;
                mis_q   <= 1'b1;
                flush_q <= 1'b1;
                redir_q <= redir;
            end
        end
    end
endmodule

// File: tb/tb_predictor_fifo_ctrl.sv
// tb_predictor_fifo_ctrl: directed and random stimulus against a queue-based model of the predictor FIFO.
module tb_predictor_fifo_ctrl;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    logic [24:0] q[$];
    bit          m_flush, m_uf, m_se;
    logic [10:0] m_redir;
    predictor_fifo_ctrl_if #(.PTR_W(3)) bus();
    predictor_fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
    always #5 clk = ~clk;
    function automatic logic [24:0] ent(logic [10:0] a, logic [10:0] j, logic [1:0] ty, logic t);
        return {a, j, ty, t};
    endfunction
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask
    task automatic drive(logic pv, logic [24:0] pd, logic rv, logic [10:0] ra, logic rt, logic [10:0] rtg);
        bus.push_valid = pv;
        bus.push_data = pd;
        bus.resolve_valid = rv;
        bus.resolve_addr = ra;
        bus.resolve_taken = rt;
        bus.resolve_target = rtg;
    endtask
    task automatic check_all();
        bit hv;
        hv = !m_flush && q.size() != 0;
        check("count", 32'(bus.count), 32'(q.size()));
        check("push_ready", 32'(bus.push_ready), 32'(!m_flush && q.size() < DEPTH));
        check("head_valid", 32'(bus.head_valid), 32'(hv));
        if (hv) check("head_data", 32'(bus.head_data), 32'(q[0]));
        check("flush", 32'(bus.flush), 32'(m_flush));
        check("mispredict", 32'(bus.mispredict), 32'(m_flush));
        if (m_flush) check("redirect_addr", 32'(bus.redirect_addr), 32'(m_redir));
        check("underflow_err", 32'(bus.underflow_err), 32'(m_uf));
        check("sync_err", 32'(bus.sync_err), 32'(m_se));
    endtask
    task automatic model();
        logic [24:0] h;
        bit full;
        if (m_flush) begin
            q.delete();
            m_flush = 0;
            return;
        end
        full = q.size() >= DEPTH;
        if (bus.resolve_valid) begin
            if (q.size() == 0) m_uf = 1;
            else begin
                h = q.pop_front();
                if (bus.resolve_addr != h[24:14]) m_se = 1;
                if (bus.resolve_addr != h[24:14] || bus.resolve_taken != h[0] ||
                    (bus.resolve_taken && h[0] && bus.resolve_target != h[13:3])) begin
                    m_flush = 1;
                    m_redir = bus.resolve_taken ? bus.resolve_target : bus.resolve_addr + 11'd1;
                end
            end
        end
        if (bus.push_valid && !full) q.push_back(bus.push_data);
    endtask
    task automatic step();
        check_all();
        @(posedge clk);
        model();
        #1;
    endtask
    task automatic idle();
        drive(0, '0, 0, '0, 0, '0);
        step();
    endtask
    task automatic push(logic [24:0] d);
        drive(1, d, 0, '0, 0, '0);
        step();
    endtask
    task automatic resolve_ok();
        drive(0, '0, 1, q[0][24:14], q[0][0], q[0][13:3]);
        step();
    endtask
    initial begin
        drive(0, '0, 0, '0, 0, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check_all();
        push(25'h0A00018);
        check("first_head", 32'(bus.head_data), 32'h0A00018);
        check("first_count", 32'(bus.count), 1);
        resolve_ok();
        for (int i = 0; i < DEPTH; i++) push(ent(11'(i + 16), 11'(i * 3), 2'(i), 1'b1));
        push(ent(11'h555, 11'h111, 2'd1, 1'b0));
        check("full_count", 32'(bus.count), 8);
        check("full_ready", 32'(bus.push_ready), 0);
        resolve_ok();
        check("after_pop_count", 32'(bus.count), 7);
        check("after_pop_ready", 32'(bus.push_ready), 1);
        while (q.size() > 0) resolve_ok();
        push(ent(11'h280, 11'h100, 2'd0, 1'b1));
        push(ent(11'h280, 11'h100, 2'd0, 1'b1));
        resolve_ok();
        check("good_no_mis", 32'(bus.mispredict), 0);
        check("good_count", 32'(bus.count), 1);
        drive(0, '0, 1, 11'h280, 1'b0, 11'h100);
        step();
        check("dir_mis", 32'(bus.mispredict), 1);
        check("dir_flush", 32'(bus.flush), 1);
        check("dir_redirect", 32'(bus.redirect_addr), 32'h281);
        idle();
        check("post_flush_count", 32'(bus.count), 0);
        check("post_flush_hv", 32'(bus.head_valid), 0);
        check("post_flush_ready", 32'(bus.push_ready), 1);
        push(ent(11'h7FF, 11'h005, 2'd1, 1'b1));
        drive(0, '0, 1, 11'h7FF, 1'b0, 11'h005);
        step();
        check("wrap_redirect", 32'(bus.redirect_addr), 0);
        idle();
        push(ent(11'h280, 11'h003, 2'd0, 1'b0));
        drive(0, '0, 1, 11'h123, 1'b0, 11'h000);
        step();
        check("sync_err", 32'(bus.sync_err), 1);
        check("sync_flush", 32'(bus.flush), 1);
        idle();
        drive(0, '0, 1, 11'h044, 1'b0, 11'h000);
        step();
        check("underflow_err", 32'(bus.underflow_err), 1);
        check("underflow_count", 32'(bus.count), 0);
        for (int i = 0; i < 3000; i++) begin
            logic [10:0] ra, rtg;
            logic rt;
            ra = 11'($urandom);
            rt = 1'($urandom);
            rtg = 11'($urandom);
            if (q.size() != 0 && $urandom_range(7) != 0) begin
                ra = q[0][24:14];
                rt = ($urandom_range(7) != 0) ? q[0][0] : ~q[0][0];
                rtg = ($urandom_range(7) != 0) ? q[0][13:3] : rtg;
            end
            drive(1'($urandom), ent(11'($urandom_range(15)), 11'($urandom), 2'($urandom), 1'($urandom)),
                  $urandom_range(2) == 0, ra, rt, rtg);
            step();
        end
        drive(0, '0, 0, '0, 0, '0);
        while (m_flush) step();
        push(ent(11'h280, 11'h100, 2'd2, 1'b1));
        drive(1, ent(11'h300, 11'h001, 2'd0, 1'b0), 1, 11'h280, 1'b0, 11'h000);
        step();
        check("pre_reset_flush", 32'(bus.flush), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_flush", 32'(bus.flush), 0);
        check("async_mis", 32'(bus.mispredict), 0);
        check("async_count", 32'(bus.count), 0);
        check("async_hv", 32'(bus.head_valid), 0);
        check("async_uf", 32'(bus.underflow_err), 0);
        check("async_se", 32'(bus.sync_err), 0);
        q.delete();
        m_flush = 0;
        m_uf = 0;
        m_se = 0;
        drive(0, '0, 0, '0, 0, '0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        push(ent(11'h010, 11'h020, 2'd3, 1'b0));
        idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
